// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: common unsigned aliases, fetch FSM states and the
// fetched-instruction payload that decode also consumes.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        u64 pc;
        u32 raw_instr;
        u1  misalign;
        u1  valid;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus and decode-side handshake of the fetch stage.
// The fetch stage is the master; the bus/decode environment is the slave.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] ireq_addr;
    logic [ILEN-1:0] iresp_data;
    logic [XLEN-1:0] inst_pc;
    logic [ILEN-1:0] inst_data;
    u1               ireq_valid;
    u1               iresp_data_ok;
    u1               inst_valid;
    u1               inst_misalign;
    u1               de_ready;

    modport master (
        output ireq_valid, ireq_addr, inst_valid, inst_pc, inst_data, inst_misalign,
        input  iresp_data_ok, iresp_data, de_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, inst_valid, inst_pc, inst_data, inst_misalign,
        output iresp_data_ok, iresp_data, de_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding bus request per PC, a one-entry
// output buffer toward decode, and flush handling that drains in-flight fetches.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter bit CHK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            stall_pc,
    input  logic            flush,
    fetch_unit_if.master    fbus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    fetch_data_t     buf_q, buf_d;
    logic            pc_misalign;

    assign pc_misalign = CHK_ALIGN && (pc[1:0] != 2'b00);

    // State, request address and output buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            buf_q    <= buf_d;
        end
    end

    // Next-state, buffer update and output decode
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        buf_d    = buf_q;

        fbus.ireq_valid    = (state_q == WAIT) || (state_q == DRAIN);
        fbus.ireq_addr     = req_pc_q;
        fbus.inst_valid    = buf_q.valid;
        fbus.inst_pc       = buf_q.pc;
        fbus.inst_data     = buf_q.raw_instr;
        fbus.inst_misalign = buf_q.misalign;
        stall_pc           = ~(buf_q.valid & fbus.de_ready);

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (pc_misalign) begin
                        buf_d.pc        = pc;
                        buf_d.raw_instr = '0;
                        buf_d.misalign  = 1'b1;
                        buf_d.valid     = 1'b1;
                        state_d         = VALID;
                    end else begin
                        req_pc_d = pc;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (fbus.iresp_data_ok) begin
                    if (!flush) begin
                        buf_d.pc        = req_pc_q;
                        buf_d.raw_instr = fbus.iresp_data;
                        buf_d.misalign  = 1'b0;
                        buf_d.valid     = 1'b1;
                        state_d         = VALID;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            // Request stays on the bus; the late response is discarded
            DRAIN: begin
                if (fbus.iresp_data_ok) begin
                    state_d = IDLE;
                end
            end
            VALID: begin
                if (flush || fbus.de_ready) begin
                    buf_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency bus responder.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [63:0] pc;
    logic        stall_pc;
    logic        flush;
    int          bus_lat;
    logic [31:0] bus_data;
    int          n_chk;
    int          n_fail;

    fetch_unit_if fbus ();

    fetch_unit #(.CHK_ALIGN(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .stall_pc (stall_pc),
        .flush    (flush),
        .fbus     (fbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus responder: one-cycle data_ok pulse bus_lat cycles into a request
    initial begin
        int cnt;
        cnt = 0;
        fbus.iresp_data_ok = 1'b0;
        fbus.iresp_data    = '0;
        forever begin
            @(negedge clk);
            fbus.iresp_data_ok = 1'b0;
            if (fbus.ireq_valid && !reset) begin
                if (cnt + 1 >= bus_lat) begin
                    fbus.iresp_data_ok = 1'b1;
                    fbus.iresp_data    = bus_data;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] pc_v);
        step();
        reset = 1'b1; flush = 1'b0; fbus.de_ready = 1'b0; pc = pc_v;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        reset = 1'b1; pc = 64'h8000_0000; fbus.de_ready = 1'b1;
        step();
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ireq_valid: got %b exp 0", fbus.ireq_valid); end
        n_chk++; if (fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b exp 0", fbus.inst_valid); end
        n_chk++; if (fbus.inst_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b exp 0", fbus.inst_misalign); end
        n_chk++; if (fbus.inst_pc !== 64'h0) begin n_fail++; $display("FAIL rst_inst_pc: got %h exp 0", fbus.inst_pc); end
        n_chk++; if (fbus.inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_inst_data: got %h exp 0", fbus.inst_data); end
        n_chk++; if (fbus.ireq_addr !== 64'h0) begin n_fail++; $display("FAIL rst_req_pc: got %h exp 0", fbus.ireq_addr); end
        n_chk++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pc: got %b exp 1", stall_pc); end
    endtask

    task automatic test_back_to_back();
        bus_lat = 1; bus_data = 32'h0000_0013;
        do_reset(64'h8000_0000);
        fbus.de_ready = 1'b1;
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_req0_valid: got %b exp 1", fbus.ireq_valid); end
        n_chk++; if (fbus.ireq_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL b2b_req0_addr: got %h exp 80000000", fbus.ireq_addr); end
        n_chk++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_wait: got %b exp 1", stall_pc); end
        step();
        n_chk++; if (fbus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_inst0_valid: got %b exp 1", fbus.inst_valid); end
        n_chk++; if (fbus.inst_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL b2b_inst0_pc: got %h exp 80000000", fbus.inst_pc); end
        n_chk++; if (fbus.inst_data !== 32'h0000_0013) begin n_fail++; $display("FAIL b2b_inst0_data: got %h exp 00000013", fbus.inst_data); end
        n_chk++; if (fbus.inst_misalign !== 1'b0) begin n_fail++; $display("FAIL b2b_inst0_mis: got %b exp 0", fbus.inst_misalign); end
        n_chk++; if (fbus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req_drop: got %b exp 0", fbus.ireq_valid); end
        n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_accept: got %b exp 0", stall_pc); end
        pc = 64'h8000_0004; bus_data = 32'h0010_0093;
        step();
        n_chk++; if (fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b exp 0", fbus.inst_valid); end
        n_chk++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_idle: got %b exp 1", stall_pc); end
        step();
        n_chk++; if (fbus.ireq_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL b2b_req1_addr: got %h exp 80000004", fbus.ireq_addr); end
        step();
        n_chk++; if (fbus.inst_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL b2b_inst1_pc: got %h exp 80000004", fbus.inst_pc); end
        n_chk++; if (fbus.inst_data !== 32'h0010_0093) begin n_fail++; $display("FAIL b2b_inst1_data: got %h exp 00100093", fbus.inst_data); end
    endtask

    task automatic test_slow_bus();
        bus_lat = 4; bus_data = 32'h00a0_0513;
        do_reset(64'h8000_1000);
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (fbus.ireq_valid !== 1'b1 || fbus.ireq_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL slow_req c%0d: got %b/%h exp 1/80001000", i, fbus.ireq_valid, fbus.ireq_addr); end
            n_chk++; if (fbus.inst_valid !== 1'b0 || stall_pc !== 1'b1) begin n_fail++; $display("FAIL slow_wait c%0d: valid/stall got %b/%b exp 0/1", i, fbus.inst_valid, stall_pc); end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (fbus.inst_valid !== 1'b1 || fbus.inst_pc !== 64'h8000_1000 || fbus.inst_data !== 32'h00a0_0513) begin n_fail++; $display("FAIL slow_hold c%0d: got %b/%h/%h exp 1/80001000/00a00513", i, fbus.inst_valid, fbus.inst_pc, fbus.inst_data); end
            n_chk++; if (stall_pc !== 1'b1 || fbus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL slow_hold_stall c%0d: stall/req got %b/%b exp 1/0", i, stall_pc, fbus.ireq_valid); end
        end
        fbus.de_ready = 1'b1;
        #1;
        n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL slow_accept_stall: got %b exp 0", stall_pc); end
        step();
        n_chk++; if (fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL slow_after_accept: got %b exp 0", fbus.inst_valid); end
    endtask

    task automatic test_flush_wait();
        bus_lat = 4; bus_data = 32'hbad0_0bad;
        do_reset(64'h8000_2000);
        step();
        step();
        flush = 1'b1; pc = 64'h8000_3000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (fbus.ireq_valid !== 1'b1 || fbus.ireq_addr !== 64'h8000_2000) begin n_fail++; $display("FAIL flw_drain_req c%0d: got %b/%h exp 1/80002000", i, fbus.ireq_valid, fbus.ireq_addr); end
            n_chk++; if (fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flw_drain_valid c%0d: got %b exp 0", i, fbus.inst_valid); end
            if (i == 1) flush = 1'b0;
        end
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b0 || fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flw_idle: req/valid got %b/%b exp 0/0", fbus.ireq_valid, fbus.inst_valid); end
        bus_data = 32'h0000_0513;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (fbus.ireq_addr !== 64'h8000_3000 || fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flw_refetch c%0d: addr/valid got %h/%b exp 80003000/0", i, fbus.ireq_addr, fbus.inst_valid); end
        end
        step();
        n_chk++; if (fbus.inst_valid !== 1'b1 || fbus.inst_pc !== 64'h8000_3000 || fbus.inst_data !== 32'h0000_0513) begin n_fail++; $display("FAIL flw_target: got %b/%h/%h exp 1/80003000/00000513", fbus.inst_valid, fbus.inst_pc, fbus.inst_data); end
    endtask

    task automatic test_flush_dataok();
        bus_lat = 2; bus_data = 32'h1111_1111;
        do_reset(64'h8000_4000);
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b1) begin n_fail++; $display("FAIL fld_req: got %b exp 1", fbus.ireq_valid); end
        step();
        flush = 1'b1; pc = 64'h8000_5000;
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b0 || fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL fld_dropped: req/valid got %b/%b exp 0/0", fbus.ireq_valid, fbus.inst_valid); end
        flush = 1'b0; bus_data = 32'h2222_2222;
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b1 || fbus.ireq_addr !== 64'h8000_5000 || fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL fld_refetch: got %b/%h/%b exp 1/80005000/0", fbus.ireq_valid, fbus.ireq_addr, fbus.inst_valid); end
        step();
        step();
        n_chk++; if (fbus.inst_valid !== 1'b1 || fbus.inst_pc !== 64'h8000_5000 || fbus.inst_data !== 32'h2222_2222) begin n_fail++; $display("FAIL fld_target: got %b/%h/%h exp 1/80005000/22222222", fbus.inst_valid, fbus.inst_pc, fbus.inst_data); end
    endtask

    task automatic test_misalign();
        bus_lat = 1; bus_data = 32'hffff_ffff;
        do_reset(64'h8000_0002);
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %b exp 0", fbus.ireq_valid); end
        n_chk++; if (fbus.inst_valid !== 1'b1 || fbus.inst_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: valid/mis got %b/%b exp 1/1", fbus.inst_valid, fbus.inst_misalign); end
        n_chk++; if (fbus.inst_data !== 32'h0 || fbus.inst_pc !== 64'h8000_0002) begin n_fail++; $display("FAIL mis_payload: data/pc got %h/%h exp 0/80000002", fbus.inst_data, fbus.inst_pc); end
        fbus.de_ready = 1'b1;
        #1;
        n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL mis_accept_stall: got %b exp 0", stall_pc); end
        step();
        n_chk++; if (fbus.inst_valid !== 1'b0 || fbus.ireq_valid !== 1'b0 || stall_pc !== 1'b1) begin n_fail++; $display("FAIL mis_idle: valid/req/stall got %b/%b/%b exp 0/0/1", fbus.inst_valid, fbus.ireq_valid, stall_pc); end
    endtask

    task automatic test_reset_mid_wait();
        bus_lat = 4; bus_data = 32'h0000_0073;
        do_reset(64'h8000_6000);
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b1) begin n_fail++; $display("FAIL rmw_req: got %b exp 1", fbus.ireq_valid); end
        step();
        reset = 1'b1;
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b0 || fbus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_cleared: req/valid got %b/%b exp 0/0", fbus.ireq_valid, fbus.inst_valid); end
        reset = 1'b0;
        step();
        n_chk++; if (fbus.ireq_valid !== 1'b1 || fbus.ireq_addr !== 64'h8000_6000) begin n_fail++; $display("FAIL rmw_fresh_req: got %b/%h exp 1/80006000", fbus.ireq_valid, fbus.ireq_addr); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1; pc = '0; flush = 1'b0; fbus.de_ready = 1'b0;
        bus_lat = 1; bus_data = '0;
        test_reset();
        test_back_to_back();
        test_slow_bus();
        test_flush_wait();
        test_flush_dataok();
        test_misalign();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
